// File: rtl/hwjsoc_dct_pkg.sv
// ----------------------------------------------------------------------------
// hwjsoc_dct_pkg
// Shared definitions for the DCT trace-code packer: code and frame widths,
// the packer state encoding and the code type.
// ----------------------------------------------------------------------------
package hwjsoc_dct_pkg;

    localparam int CODE_W = 2;                 // bits per DCT code
    localparam int SLOTS  = 15;                // codes per full frame
    localparam int BUF_W  = CODE_W * SLOTS;    // 30-bit frame buffer
    localparam int CNT_W  = 4;                 // holds 0..15

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // accepting codes
        FLUSH = 2'd1,   // pushing out the partial frame
        DRAIN = 2'd2,   // waiting for the last frame to be taken
        ENDED = 2'd3    // terminal until reset
    } dct_state_t;

    typedef logic [CODE_W-1:0] dct_code_t;

endpackage

// File: rtl/hwjsoc_dct_frame_reg.sv
// ----------------------------------------------------------------------------
// hwjsoc_dct_frame_reg
// One-entry output register for packed DCT frames.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset (clears entry)
//   load         - capture load_buf/load_cnt and mark the entry valid
//   load_buf     - frame data to capture
//   load_cnt     - number of valid codes in the frame
//   ready        - sink accepts the frame this cycle
//   valid        - entry holds a frame
//   buffer/count - registered frame data, held while valid is low
//
// Handshake: a frame moves when valid && ready on a rising edge. Once valid
// is high, valid, buffer and count stay stable until that handshake. The
// owner only asserts load when the slot is free (!valid || ready), so a load
// on the handshake edge replaces the departing frame without a bubble.
// ----------------------------------------------------------------------------
module hwjsoc_dct_frame_reg
    import hwjsoc_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buf,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             ready,
    output logic             valid,
    output logic [BUF_W-1:0] buffer,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            buffer <= '0;
            count  <= '0;
        end else begin
            if (load) begin
                valid  <= 1'b1;
                buffer <= load_buf;
                count  <= load_cnt;
            end else if (valid && ready) begin
                // Data is left in place; only the valid flag drops.
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hwjsoc_cpu_d_oci_dct_packer.sv
// ----------------------------------------------------------------------------
// hwjsoc_cpu_d_oci_dct_packer
// Packs 2-bit direct-branch trace codes into 30-bit frames of up to 15 codes
// for the OCI test-bench monitor / trace sink. At end of test the partial
// frame is flushed, the last frame drained, and test_has_ended is raised.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   code_valid      - a code is offered
//   code            - the DCT code
//   code_ready      - packer accepts the code this cycle
//   test_ending     - level request to flush and finish (sampled in RUN only)
//   frame_valid     - dct_buffer/dct_count hold a frame
//   frame_ready     - sink takes the frame
//   dct_buffer      - packed codes, newest at [1:0], unused upper slots 0
//   dct_count       - number of valid codes in the frame (1..15)
//   test_has_ended  - sticky, flush complete
//   dbg_state       - current packer state, for observation only
//
// Handshakes: both the code input and the frame output use valid/ready; a
// transfer happens on a rising edge where valid && ready are both high, and
// valid never depends combinationally on ready.
// ----------------------------------------------------------------------------
module hwjsoc_cpu_d_oci_dct_packer
    import hwjsoc_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  dct_code_t        code,
    output logic             code_ready,
    input  logic             test_ending,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             test_has_ended,
    output dct_state_t       dbg_state
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    logic [BUF_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    dct_state_t       state;

    logic accept;
    logic slot_free;
    logic xfer;

    // Ready drops once the accumulator is full; it stays low until the
    // transfer empties it, which is the single bubble per frame.
    assign code_ready = (state == RUN) && (acc_cnt < FULL_CNT);
    assign accept     = code_valid && code_ready;
    assign slot_free  = !frame_valid || frame_ready;

    // A full frame moves in RUN; any non-empty remainder moves in FLUSH.
    assign xfer = slot_free &&
                  (((state == RUN)   && (acc_cnt == FULL_CNT)) ||
                   ((state == FLUSH) && (acc_cnt != '0)));

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            acc_cnt        <= '0;
            state          <= RUN;
            test_has_ended <= 1'b0;
        end else begin
            // accept and xfer are mutually exclusive: xfer needs either a
            // full accumulator (ready low) or FLUSH (ready low).
            if (xfer) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (accept) begin
                acc     <= {acc[BUF_W-CODE_W-1:0], code};
                acc_cnt <= acc_cnt + CNT_W'(1);
            end

            case (state)
                RUN: begin
                    // A code accepted on this same edge is already in acc
                    // when FLUSH looks at it.
                    if (test_ending) state <= FLUSH;
                end
                FLUSH: begin
                    if ((acc_cnt == '0) || xfer) state <= DRAIN;
                end
                DRAIN: begin
                    if (slot_free) state <= ENDED;
                end
                ENDED: begin
                    state <= ENDED;
                end
                default: begin
                    state <= RUN;
                end
            endcase

            test_has_ended <= (state == ENDED);
        end
    end

    hwjsoc_dct_frame_reg u_frame_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (xfer),
        .load_buf (acc),
        .load_cnt (acc_cnt),
        .ready    (frame_ready),
        .valid    (frame_valid),
        .buffer   (dct_buffer),
        .count    (dct_count)
    );

endmodule

// File: tb/tb_hwjsoc_cpu_d_oci_dct_packer.sv
// ----------------------------------------------------------------------------
// tb_hwjsoc_cpu_d_oci_dct_packer
// Directed and random stimulus for the DCT packer. A reference model keeps
// the accepted codes in a queue; every 15 codes, or at end of test, it packs
// them into an expected {count, buffer} entry in exp_q. Every output
// handshake is checked against the head of exp_q.
// ----------------------------------------------------------------------------
module tb_hwjsoc_cpu_d_oci_dct_packer;
    import hwjsoc_dct_pkg::*;

    localparam int W = CNT_W + BUF_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             code_valid = 1'b0;
    dct_code_t        code = '0;
    logic             code_ready;
    logic             test_ending = 1'b0;
    logic             frame_valid;
    logic             frame_ready = 1'b0;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             test_has_ended;
    dct_state_t       dbg_state;

    hwjsoc_cpu_d_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .code_valid     (code_valid),
        .code           (code),
        .code_ready     (code_ready),
        .test_ending    (test_ending),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_q[$];
    dct_code_t     acc_q[$];
    bit            model_run = 1'b1;
    bit            last_accept = 1'b0;
    bit            prev_hold = 1'b0;
    logic [W-1:0]  prev_frame = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Older codes end up in the higher slots, newest at [1:0].
    function automatic logic [W-1:0] pack_acc();
        logic [BUF_W-1:0] b;
        b = '0;
        foreach (acc_q[i]) b = (b << CODE_W) | BUF_W'(acc_q[i]);
        return {CNT_W'(acc_q.size()), b};
    endfunction

    task automatic close_frame();
        exp_q.push_back(pack_acc());
        acc_q.delete();
    endtask

    // One clock cycle: observe what the coming edge will do at the negedge,
    // update the model, then return just after the rising edge.
    task automatic cycle();
        logic [W-1:0] head;
        @(negedge clk);
        last_accept = 1'b0;
        if (reset) begin
            acc_q.delete();
            exp_q.delete();
            model_run = 1'b1;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check("hold_stable", {frame_valid, dct_count, dct_buffer}, {1'b1, prev_frame});
            if (code_valid && code_ready) begin
                last_accept = 1'b1;
                acc_q.push_back(code);
                if (acc_q.size() == SLOTS) close_frame();
            end
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {dct_count, dct_buffer}, '0);
                end else begin
                    head = exp_q.pop_front();
                    check("frame_data", {dct_count, dct_buffer}, head);
                end
            end
            if (model_run && test_ending) begin
                model_run = 1'b0;
                if (acc_q.size() > 0) close_frame();
            end
            prev_hold  = frame_valid && !frame_ready;
            prev_frame = {dct_count, dct_buffer};
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        code_valid = 1'b0;
        test_ending = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic send_code(input dct_code_t c, input int budget);
        int n;
        code_valid = 1'b1;
        code = c;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_accept && n < budget);
        code_valid = 1'b0;
        if (!last_accept) check("send_timeout", 64'(n), 64'(budget + 1));
    endtask

    task automatic pulse_ending();
        test_ending = 1'b1;
        cycle();
        test_ending = 1'b0;
    endtask

    task automatic wait_ended(input int budget);
        int n;
        n = 0;
        while (!test_has_ended && n < budget) begin
            cycle();
            n++;
        end
        check("ended_reached", 64'(test_has_ended), 64'(1));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        cycle();
        do_reset();

        // Reset state
        check("rst_frame_valid", 64'(frame_valid), 64'(0));
        check("rst_buffer", 64'(dct_buffer), 64'(0));
        check("rst_count", 64'(dct_count), 64'(0));
        check("rst_ended", 64'(test_has_ended), 64'(0));
        check("rst_code_ready", 64'(code_ready), 64'(1));

        // Full frame: 15 x 2'b01, ready drops for exactly one cycle
        frame_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            code_valid = (i < 15);
            code = 2'b01;
            check("full_code_ready", 64'(code_ready), 64'(i != 15));
            check("full_frame_valid", 64'(frame_valid), 64'(i == 16));
            if (i == 16) begin
                check("full_buffer", 64'(dct_buffer), 64'h15555555);
                check("full_count", 64'(dct_count), 64'd15);
            end
            cycle();
        end

        // Partial flush: 3,0,0 then test_ending
        do_reset();
        frame_ready = 1'b1;
        send_code(2'd3, 4);
        send_code(2'd0, 4);
        send_code(2'd0, 4);
        pulse_ending();
        for (int i = 0; i < 7; i++) begin
            check("pf_frame_valid", 64'(frame_valid), 64'(i == 1));
            check("pf_ended", 64'(test_has_ended), 64'(i >= 3));
            if (i == 1) begin
                check("pf_buffer", 64'(dct_buffer), 64'h30);
                check("pf_count", 64'(dct_count), 64'd3);
            end
            cycle();
        end
        check("pf_code_ready", 64'(code_ready), 64'(0));

        // Empty end: test_ending sampled from idle
        do_reset();
        test_ending = 1'b1;
        check("ee_ended_c0", 64'(test_has_ended), 64'(0));
        cycle();
        test_ending = 1'b0;
        for (int i = 1; i < 7; i++) begin
            check("ee_ended", 64'(test_has_ended), 64'(i >= 4));
            check("ee_frame_valid", 64'(frame_valid), 64'(0));
            cycle();
        end

        // Simultaneous code and test_ending with 4 codes buffered
        do_reset();
        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_code(dct_code_t'($urandom_range(0, 3)), 4);
        code_valid = 1'b1;
        code = 2'b10;
        test_ending = 1'b1;
        check("sim_code_ready", 64'(code_ready), 64'(1));
        cycle();
        code_valid = 1'b0;
        test_ending = 1'b0;
        begin
            int n;
            n = 0;
            while (!frame_valid && n < 10) begin
                cycle();
                n++;
            end
        end
        check("sim_frame_valid", 64'(frame_valid), 64'(1));
        check("sim_count", 64'(dct_count), 64'd5);
        check("sim_newest", 64'(dct_buffer[1:0]), 64'(2'b10));
        wait_ended(10);

        // Backpressure: 40 cyclic codes, sink stalled for the first two frames
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) send_code(dct_code_t'(i % 4), 4);
        code_valid = 1'b1;
        code = 2'(30 % 4);
        for (int i = 0; i < 5; i++) begin
            check("bp_code_ready", 64'(code_ready), 64'(0));
            check("bp_frame_valid", 64'(frame_valid), 64'(1));
            cycle();
        end
        code_valid = 1'b0;
        frame_ready = 1'b1;
        for (int i = 30; i < 40; i++) send_code(dct_code_t'(i % 4), 6);
        pulse_ending();
        wait_ended(20);

        // Reset mid-operation: frame pending and 7 codes buffered
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) send_code(dct_code_t'($urandom_range(0, 3)), 4);
        check("rm_pending", 64'(frame_valid), 64'(1));
        do_reset();
        check("rm_frame_valid", 64'(frame_valid), 64'(0));
        check("rm_buffer", 64'(dct_buffer), 64'(0));
        check("rm_count", 64'(dct_count), 64'(0));
        check("rm_ended", 64'(test_has_ended), 64'(0));
        check("rm_code_ready", 64'(code_ready), 64'(1));
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_code(dct_code_t'($urandom_range(0, 3)), 4);
        for (int i = 0; i < 3; i++) cycle();
        check("rm_clean_frame", 64'(exp_q.size()), 64'(0));

        // Random traffic with random backpressure, then flush
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                code_valid  = ($urandom_range(0, 3) != 0);
                code        = dct_code_t'($urandom_range(0, 3));
                frame_ready = ($urandom_range(0, 2) != 0);
                cycle();
            end
            code_valid = 1'b0;
            pulse_ending();
            frame_ready = 1'b1;
            wait_ended(30);
            check("rnd_code_ready", 64'(code_ready), 64'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
